// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: FSM states, opcodes,
// datapath select codes and fault codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_FAULT
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state; expired flags that the
// tolerated stall budget has been used up.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int unsigned W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_WAIT_MAX);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (clear)
      wait_cnt <= '0;
    else if (stall && wait_cnt != LIMIT)
      wait_cnt <= wait_cnt + W'(1);
  end

  assign expired = (wait_cnt == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: per-state datapath controls, memory ready
// handshake with stall timeout, retired-instruction counter, sticky fault.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned RETIRE_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                adr_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          imm_src,
  output logic [1:0]          result_src,
  output logic                retire,
  output logic [RETIRE_W-1:0] retired_count,
  output logic                fault,
  output logic [1:0]          fault_code
);

  state_t     state, state_next;
  logic [1:0] fault_code_next;
  logic       wait_state, stall, expired, timeout;
  logic       unused_funct3;

  assign unused_funct3 = ^funct3[2:1];
  assign wait_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign stall         = wait_state && !mem_ready;
  assign timeout       = stall && expired;
  assign fault         = (state == S_FAULT);

  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .stall  (stall),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      fault_code    <= FAULT_NONE;
      retired_count <= '0;
    end else begin
      state      <= state_next;
      fault_code <= fault_code_next;
      if (retire)
        retired_count <= retired_count + RETIRE_W'(1);
    end
  end

  // Controls are decoded only while reset is low, so an async reset drops
  // every strobe within the same cycle rather than at the next edge.
  always_comb begin
    state_next      = state;
    fault_code_next = fault_code;
    pc_write        = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    adr_src         = 1'b0;
    alu_src_a       = SRCA_PC;
    alu_src_b       = SRCB_RS2;
    alu_op          = ALU_ADD;
    imm_src         = IMM_I;
    result_src      = RES_ALUOUT;
    retire          = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end else if (timeout) begin
            state_next      = S_FAULT;
            fault_code_next = FAULT_TIMEOUT;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = imm_src_for(opcode);
          case (opcode)
            OP_R:         state_next = S_EXEC_R;
            OP_I:         state_next = S_EXEC_I;
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_BR:        state_next = S_BRANCH;
            default: begin
              state_next      = S_FAULT;
              fault_code_next = FAULT_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
          if (mem_ready) begin
            state_next = S_MEMWB;
          end else if (timeout) begin
            state_next      = S_FAULT;
            fault_code_next = FAULT_TIMEOUT;
          end
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = RES_MDR;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else if (timeout) begin
            state_next      = S_FAULT;
            fault_code_next = FAULT_TIMEOUT;
          end
        end
        S_EXEC_R: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_EXEC_I: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          result_src = RES_ALUOUT;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALU_SUB;
          result_src = RES_ALUOUT;
          imm_src    = IMM_B;
          retire     = 1'b1;
          pc_write   = zero ^ funct3[0];
          state_next = S_FETCH;
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the RV32I subset the single-cycle core supports (R-type, I-type ALU, LW, SW, BEQ/BNE). It replaces the combinational control_unit when the datapath shares one memory port and one ALU across cycles. It drives mux selects and write enables per state, waits on a memory ready handshake, and counts retired instructions. Illegal opcodes and memory timeouts trap it in a sticky fault state.

Parameters:
MEM_WAIT_MAX, 15, maximum stalled cycles tolerated in a memory-wait state before timeout fault
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  7  instruction[6:0] from the instruction register
funct3  in  3  instruction[14:12]; bit0 selects BEQ(0) or BNE(1)
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC register enable
ir_write  out  1  instruction register enable
reg_write  out  1  register file write enable
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
alu_op  out  2  00 = add, 01 = sub, 10 = decode by funct
imm_src  out  2  00 = I, 01 = S, 10 = B
result_src  out  2  00 = ALUOut, 01 = memory data register, 10 = ALU result
retire  out  1  one-cycle pulse when an instruction completes
retired_count  out  RETIRE_W  retired instructions, wraps to 0
fault  out  1  sticky fault flag
fault_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, FAULT.
- Reset: state = FETCH, wait_cnt = 0, retired_count = 0, fault = 0, fault_code = 00.
- While reset is high, every enable, strobe and select output is forced to 0.
- All outputs are zero unless a state listed below sets them.
- FETCH:
  - Sets mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - If mem_ready: ir_write=1 and pc_write=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Sets alu_src_a=01, alu_src_b=01, alu_op=00; imm_src is set from the opcode.
  - 0110011 goes to EXEC_R. 0010011 goes to EXEC_I. 0000011 and 0100011 go to MEMADR. 1100011 goes to BRANCH.
  - Any other opcode goes to FAULT with fault_code=01.
- MEMADR: sets alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: sets mem_read=1, adr_src=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: sets reg_write=1, result_src=01, retire=1. Next state FETCH.
- MEMWR: sets mem_write=1, adr_src=1. Waits for mem_ready; on mem_ready sets retire=1 and goes to FETCH.
- EXEC_R: sets alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXEC_I: sets alu_src_a=10, alu_src_b=01, alu_op=10. Next state ALUWB.
- ALUWB: sets reg_write=1, result_src=00, retire=1. Next state FETCH.
- BRANCH:
  - Sets alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, imm_src=10, retire=1.
  - pc_write = zero XOR funct3[0]. Next state FETCH.
- Wait states (FETCH, MEMRD, MEMWR):
  - wait_cnt increments each cycle that mem_ready is low.
  - wait_cnt clears on any state change.
  - If wait_cnt == MEM_WAIT_MAX and mem_ready is low, next state is FAULT with fault_code=10.
  - If mem_ready is high in that same cycle, the access completes and no fault is raised (ready wins).
- FAULT: absorbing state. All enables are 0 and fault=1. Only reset exits it.
- retired_count increments on retire and wraps to 0 past all-ones.
- Latency with zero-wait memory:
  - R-type and I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
- Reset asserted mid-instruction drops all strobes immediately; the partial instruction is not counted.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encoding localparams;
  - opcode constants;
  - alu_op, imm_src, result_src, alu_src_a and alu_src_b codes;
  - fault codes.
  control_unit also uses these.
- One sub-module, mem_wait_timer, holds wait_cnt:
  - inputs: clk, reset, clear, stall;
  - output: expired;
  - parameterised by MEM_WAIT_MAX.

Test Plan:
- ADD (0110011), mem_ready=1 constantly -> states FETCH, DECODE, EXEC_R, ALUWB. reg_write=1 only in cycle 4, retire pulse in cycle 4, retired_count=1.
- LW (0000011), mem_ready low for 3 cycles in MEMRD -> 8 cycles total. mem_read and adr_src=1 are held throughout MEMRD; reg_write=1 with result_src=01 in the final cycle.
- Branch cases:
  - BEQ, funct3=000, zero=1 -> pc_write=1 in BRANCH.
  - BNE, funct3=001, zero=1 -> pc_write=0.
  - BNE, zero=0 -> pc_write=1.
  - Each branch takes 3 cycles.
- Opcode 1111111 -> FAULT after DECODE with fault=1, fault_code=01. Thereafter no pc_write, mem_read or retire. Pulsing reset returns the block to FETCH with fault=0.
- MEM_WAIT_MAX=4, mem_ready held low in FETCH -> FAULT with fault_code=10 after 5 stalled cycles. A repeat run that raises mem_ready on the 5th stalled cycle reaches DECODE with no fault.
- Reset asserted asynchronously mid-MEMWR -> mem_write falls immediately (before the next edge). After release the state is FETCH and retired_count=0.
